// File: rtl/middle_square_prng.sv
// Registered middle-square generator with valid/ready output, seed load, saturating
// transfer counter and sticky degeneracy flag. Define MIDSQ_WEYL_EN to add a Weyl accumulator.
module middle_square_prng #(
    parameter int unsigned             WIDTH       = 32,
    parameter int unsigned             COUNT_WIDTH = 16,
    parameter logic [WIDTH-1:0]        WEYL_INC    = WIDTH'(32'hB5AD4ECB)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   seedLoad,
    input  logic [WIDTH-1:0]       seed,
    input  logic                   randomReady,
    output logic                   randomValid,
    output logic [WIDTH-1:0]       generatedRandom,
    output logic [COUNT_WIDTH-1:0] randomCount,
    output logic                   degenerate
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] VALID   = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [WIDTH-1:0]       s_q, s_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic                   valid_q, valid_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   degen_q, degen_d;

    logic [WIDTH/2-1:0]     mid;
    logic [WIDTH-1:0]       sq;
    logic [WIDTH-1:0]       next;
    logic                   step;

    assign mid = s_q[3*WIDTH/4-1 : WIDTH/4];
    assign sq  = WIDTH'(mid) * WIDTH'(mid);

`ifdef MIDSQ_WEYL_EN
    logic [WIDTH-1:0] w_q, w_d;
    logic [WIDTH-1:0] w_step;

    assign w_step = w_q + WEYL_INC;
    assign next   = sq + w_step;
`else
    logic unused_weyl_inc;

    assign unused_weyl_inc = ^WEYL_INC;
    assign next            = sq;
`endif

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        out_d   = out_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        degen_d = degen_q;
        step    = 1'b0;
`ifdef MIDSQ_WEYL_EN
        w_d     = w_q;
`endif

        if (seedLoad) begin
            // Restart wins over any handshake this cycle: advance discarded, counter cleared.
            state_d = COMPUTE;
            s_d     = seed;
            valid_d = 1'b0;
            cnt_d   = '0;
            degen_d = 1'b0;
`ifdef MIDSQ_WEYL_EN
            w_d     = '0;
`endif
        end else begin
            case (state_q)
                IDLE: ;
                COMPUTE: begin
                    step    = 1'b1;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
                VALID: begin
                    if (valid_q && randomReady) begin
                        step = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (step) begin
            s_d     = next;
            out_d   = next;
            degen_d = degen_q | (mid == '0);
`ifdef MIDSQ_WEYL_EN
            w_d     = w_step;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            degen_q <= 1'b0;
`ifdef MIDSQ_WEYL_EN
            w_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            degen_q <= degen_d;
`ifdef MIDSQ_WEYL_EN
            w_q     <= w_d;
`endif
        end
    end

    assign randomValid     = valid_q;
    assign generatedRandom = out_q;
    assign randomCount     = cnt_q;
    assign degenerate      = degen_q;

endmodule
